// File: rtl/joypad_multitap.sv
// Console-side joypad port emulation.
// Presents up to five parallel joypad states to the core as the console's
// active-low 4-bit SEL/CLR nibble port. SEL rising edges can step through
// pads when the port acts as a multitap. CLR rising edges toggle the
// 6-button bank of every pad that reports 6-button mode.

package joypad_pkg;

   // One pad's live state, as delivered by the framework HMI struct.
   // The b field is indexed 1..6 to match the button numbering on the pad.
   typedef struct packed {
      logic       mode2;
      logic       mode1;
      logic       run;
      logic       select;
      logic [6:1] b;
      logic       l;
      logic       d;
      logic       r;
      logic       u;
   } joypad_t;

endpackage

module joypad_multitap
   import joypad_pkg::*;
#(
   parameter int NUM_PADS = 5,
   parameter bit MULTITAP = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  joypad_t [NUM_PADS-1:0]   pads,
   input  logic                     sel,
   input  logic                     clr,
   output logic [3:0]               d_out,
   output logic [2:0]               pad_idx
);

   // Index value meaning "stepped past the last pad"; the port reads as empty there.
   localparam logic [2:0] LAST_IDX = 3'(NUM_PADS);

   logic                sel_q;
   logic                clr_q;
   logic [NUM_PADS-1:0] bank;

   logic                sel_rise;
   logic                clr_rise;
   joypad_t             cur_pad;
   logic                cur_bank;
   logic                pad_present;
   logic [3:0]          nibble;
   logic [2:0]          idx_next;
   logic [NUM_PADS-1:0] bank_next;
   logic                unused_mode2;

   // Edge detection against the previous-cycle line levels.
   always_comb begin
      sel_rise = sel & ~sel_q;
      clr_rise = clr & ~clr_q;
   end

   // Select the addressed pad and its bank.
   // A compare loop is used so that an index past NUM_PADS never reaches
   // an out-of-range array access; it simply leaves pad_present low.
   always_comb begin
      cur_pad     = '0;
      cur_bank    = 1'b0;
      pad_present = 1'b0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (pad_idx == 3'(i)) begin
            cur_pad     = pads[i];
            cur_bank    = bank[i];
            pad_present = 1'b1;
         end
      end
   end

   // Build the next nibble from current inputs and the pre-update index/bank.
   // Buttons are active high on the pad side and active low on the console side.
   always_comb begin
      nibble = 4'hF;
      if (clr) begin
         nibble = 4'h0;
      end else if (!pad_present) begin
         nibble = 4'hF;
      end else begin
         case ({cur_bank, sel})
            2'b01:   nibble = ~{cur_pad.l, cur_pad.d, cur_pad.r, cur_pad.u};
            2'b00:   nibble = ~{cur_pad.run, cur_pad.select, cur_pad.b[2], cur_pad.b[1]};
            2'b11:   nibble = 4'h0;
            default: nibble = ~{cur_pad.b[6], cur_pad.b[5], cur_pad.b[4], cur_pad.b[3]};
         endcase
      end
   end

   // Multitap index: CLR restarts the scan and beats a simultaneous SEL edge.
   // The index saturates one past the last pad instead of wrapping.
   always_comb begin
      idx_next = pad_idx;
      if (!MULTITAP) begin
         idx_next = 3'd0;
      end else if (clr) begin
         idx_next = 3'd0;
      end else if (sel_rise && (pad_idx < LAST_IDX)) begin
         idx_next = pad_idx + 3'd1;
      end
   end

   // Bank toggling: only 6-button pads flip on a CLR edge.
   // A pad in 2-button mode is pinned to bank 0 so it never shows the extra buttons.
   always_comb begin
      bank_next = bank;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (!pads[i].mode1) begin
            bank_next[i] = 1'b0;
         end else if (clr_rise) begin
            bank_next[i] = ~bank[i];
         end
      end
   end

   // mode2 is carried in the pad struct but has no effect on this port.
   always_comb begin
      unused_mode2 = 1'b0;
      for (int i = 0; i < NUM_PADS; i++) begin
         unused_mode2 = unused_mode2 ^ pads[i].mode2;
      end
   end

   // State registers with synchronous reset; the output nibble is registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_out   <= 4'hF;
         pad_idx <= 3'd0;
         bank    <= '0;
         sel_q   <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         d_out   <= nibble;
         pad_idx <= idx_next;
         bank    <= bank_next;
         sel_q   <= sel;
         clr_q   <= clr;
      end
   end

endmodule

// File: tb/tb_joypad_multitap.sv
// Testbench for joypad_multitap.
// Two instances: a five-pad multitap and a single-pad port with multitap off.
// Each vector drives one cycle of inputs and pushes its expected post-edge
// outputs to a scoreboard, which is popped and compared after the edge.

module tb_joypad_multitap;
   import joypad_pkg::*;

   logic                clk;
   logic                reset5;
   logic                sel5;
   logic                clr5;
   joypad_t [4:0]       pads5;
   logic [3:0]          d_out5;
   logic [2:0]          pad_idx5;

   logic                reset1;
   logic                sel1;
   logic                clr1;
   joypad_t [0:0]       pads1;
   logic [3:0]          d_out1;
   logic [2:0]          pad_idx1;

   typedef struct {
      string      name;
      bit         tgt;
      logic       rst;
      logic       sel;
      logic       clr;
      int         pid;
      joypad_t    pv;
      logic [3:0] exp_d;
      logic [2:0] exp_idx;
   } vec_t;

   typedef struct {
      string      name;
      bit         tgt;
      logic [3:0] d;
      logic [2:0] idx;
   } exp_t;

   vec_t vecs[$];
   exp_t scoreboard[$];
   int   checks;
   int   errors;

   joypad_t pNone;
   joypad_t pUr;
   joypad_t pB1Run;
   joypad_t p6b;
   joypad_t p2b;

   joypad_multitap #(.NUM_PADS(5), .MULTITAP(1'b1)) dut5 (
      .clk     (clk),
      .reset   (reset5),
      .pads    (pads5),
      .sel     (sel5),
      .clr     (clr5),
      .d_out   (d_out5),
      .pad_idx (pad_idx5)
   );

   joypad_multitap #(.NUM_PADS(1), .MULTITAP(1'b0)) dut1 (
      .clk     (clk),
      .reset   (reset1),
      .pads    (pads1),
      .sel     (sel1),
      .clr     (clr1),
      .d_out   (d_out1),
      .pad_idx (pad_idx1)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addVec(input string name, input bit tgt, input logic rst,
                         input logic sel, input logic clr, input int pid,
                         input joypad_t pv, input logic [3:0] ed, input logic [2:0] ei);
      vec_t v;
      v.name    = name;
      v.tgt     = tgt;
      v.rst     = rst;
      v.sel     = sel;
      v.clr     = clr;
      v.pid     = pid;
      v.pv      = pv;
      v.exp_d   = ed;
      v.exp_idx = ei;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      if (v.tgt == 1'b0) begin
         reset5 = v.rst;
         sel5   = v.sel;
         clr5   = v.clr;
         if (v.pid >= 0) pads5[v.pid] = v.pv;
      end else begin
         reset1 = v.rst;
         sel1   = v.sel;
         clr1   = v.clr;
         if (v.pid >= 0) pads1[0] = v.pv;
      end
      e.name = v.name;
      e.tgt  = v.tgt;
      e.d    = v.exp_d;
      e.idx  = v.exp_idx;
      scoreboard.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t       e;
      logic [3:0] gotD;
      logic [2:0] gotIdx;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries, want at least 1");
         return;
      end
      e      = scoreboard.pop_front();
      gotD   = (e.tgt == 1'b0) ? d_out5   : d_out1;
      gotIdx = (e.tgt == 1'b0) ? pad_idx5 : pad_idx1;
      checks++;
      if (gotD !== e.d) begin
         errors++;
         $display("[TB] FAIL %s d_out: got %h want %h", e.name, gotD, e.d);
      end
      checks++;
      if (gotIdx !== e.idx) begin
         errors++;
         $display("[TB] FAIL %s pad_idx: got %0d want %0d", e.name, gotIdx, e.idx);
      end
   endtask

   initial begin
      pNone  = '0;
      pUr    = '0; pUr.u = 1'b1; pUr.r = 1'b1;
      pB1Run = '0; pB1Run.b[1] = 1'b1; pB1Run.run = 1'b1;
      p6b    = '0; p6b.mode1 = 1'b1; p6b.b[3] = 1'b1;
      p2b    = '0; p2b.b[2] = 1'b1; p2b.b[3] = 1'b1;

      reset5 = 1'b1; sel5 = 1'b0; clr5 = 1'b0; pads5 = '0;
      reset1 = 1'b1; sel1 = 1'b0; clr1 = 1'b0; pads1 = '0;
      checks = 0;
      errors = 0;

      // Five-pad multitap: reset, direction and button reads.
      addVec("reset",      0, 1, 0, 0, -1, pNone,  4'hF, 3'd0);
      addVec("ur_sel",     0, 0, 1, 0,  0, pUr,    4'hC, 3'd1);
      addVec("clr_home",   0, 0, 0, 1, -1, pNone,  4'h0, 3'd0);
      addVec("b1_run",     0, 0, 0, 0,  0, pB1Run, 4'h6, 3'd0);
      addVec("released",   0, 0, 0, 0,  0, pNone,  4'hF, 3'd0);

      // Six SEL rises: index walks 0..5 and saturates; pad 4 holds up+right.
      addVec("scan_clr",   0, 0, 0, 1,  4, pUr,    4'h0, 3'd0);
      addVec("scan_r1",    0, 0, 1, 0, -1, pNone,  4'hF, 3'd1);
      addVec("scan_f1",    0, 0, 0, 0, -1, pNone,  4'hF, 3'd1);
      addVec("scan_r2",    0, 0, 1, 0, -1, pNone,  4'hF, 3'd2);
      addVec("scan_f2",    0, 0, 0, 0, -1, pNone,  4'hF, 3'd2);
      addVec("scan_r3",    0, 0, 1, 0, -1, pNone,  4'hF, 3'd3);
      addVec("scan_f3",    0, 0, 0, 0, -1, pNone,  4'hF, 3'd3);
      addVec("scan_r4",    0, 0, 1, 0, -1, pNone,  4'hF, 3'd4);
      addVec("scan_f4",    0, 0, 0, 0, -1, pNone,  4'hF, 3'd4);
      addVec("scan_r5",    0, 0, 1, 0, -1, pNone,  4'hC, 3'd5);
      addVec("scan_f5",    0, 0, 0, 0, -1, pNone,  4'hF, 3'd5);
      addVec("scan_r6sat", 0, 0, 1, 0, -1, pNone,  4'hF, 3'd5);
      addVec("scan_f6sat", 0, 0, 0, 0, -1, pNone,  4'hF, 3'd5);

      // CLR and SEL rising together at index 3: CLR wins.
      addVec("pri_clr",    0, 0, 0, 1, -1, pNone,  4'h0, 3'd0);
      addVec("pri_r1",     0, 0, 1, 0, -1, pNone,  4'hF, 3'd1);
      addVec("pri_f1",     0, 0, 0, 0, -1, pNone,  4'hF, 3'd1);
      addVec("pri_r2",     0, 0, 1, 0, -1, pNone,  4'hF, 3'd2);
      addVec("pri_f2",     0, 0, 0, 0, -1, pNone,  4'hF, 3'd2);
      addVec("pri_r3",     0, 0, 1, 0, -1, pNone,  4'hF, 3'd3);
      addVec("pri_f3",     0, 0, 0, 0, -1, pNone,  4'hF, 3'd3);
      addVec("pri_both",   0, 0, 1, 1, -1, pNone,  4'h0, 3'd0);

      // Bank toggling: pad 1 in 6-button mode, pad 0 in 2-button mode.
      addVec("bk_pad1",    0, 0, 0, 0,  1, p6b,    4'hF, 3'd0);
      addVec("bk_pad0",    0, 0, 0, 0,  0, p2b,    4'hD, 3'd0);
      addVec("bk_clr1",    0, 0, 0, 1, -1, pNone,  4'h0, 3'd0);
      addVec("bk_p0_sel0", 0, 0, 0, 0, -1, pNone,  4'hD, 3'd0);
      addVec("bk_p0_sel1", 0, 0, 1, 0, -1, pNone,  4'hF, 3'd1);
      addVec("bk_p1_id",   0, 0, 1, 0, -1, pNone,  4'h0, 3'd1);
      addVec("bk_p1_b3",   0, 0, 0, 0, -1, pNone,  4'hE, 3'd1);
      addVec("bk_clr2",    0, 0, 0, 1, -1, pNone,  4'h0, 3'd0);
      addVec("bk_back_r",  0, 0, 1, 0, -1, pNone,  4'hF, 3'd1);
      addVec("bk0_p1_s0",  0, 0, 0, 0, -1, pNone,  4'hF, 3'd1);
      addVec("bk0_p1_s1",  0, 0, 1, 0, -1, pNone,  4'hF, 3'd2);
      addVec("mid_reset5", 0, 1, 0, 0, -1, pNone,  4'hF, 3'd0);

      // Single pad, multitap off: index pinned at 0, bank 1 after one CLR edge.
      addVec("s_reset",    1, 1, 0, 0, -1, pNone,  4'hF, 3'd0);
      addVec("s_bank0",    1, 0, 0, 0,  0, p6b,    4'hF, 3'd0);
      addVec("s_clr",      1, 0, 0, 1, -1, pNone,  4'h0, 3'd0);
      addVec("s_bank1",    1, 0, 0, 0, -1, pNone,  4'hE, 3'd0);
      for (int k = 1; k <= 10; k++) begin
         addVec($sformatf("s_rise%0d", k), 1, 0, 1, 0, -1, pNone, 4'h0, 3'd0);
         addVec($sformatf("s_fall%0d", k), 1, 0, 0, 0, -1, pNone, 4'hE, 3'd0);
      end
      addVec("s_mid_rst",  1, 1, 1, 0, -1, pNone,  4'hF, 3'd0);
      addVec("s_after0",   1, 0, 0, 0, -1, pNone,  4'hF, 3'd0);
      addVec("s_after1",   1, 0, 1, 0, -1, pNone,  4'hF, 3'd0);

      // Drive each vector, let the edge happen, then compare away from the edge.
      foreach (vecs[n]) begin
         applyStimulus(vecs[n]);
         @(posedge clk);
         #1;
         checkOutput();
      end

      checks++;
      if (scoreboard.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", scoreboard.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
